decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/register_file.sv | 47 ++++
 rtl/decode_stage.sv | 98 +++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode constants and the ID/EX bundle for the decode stage.
// The bundle struct is the single definition of what crosses from decode into execute.
package cpu_pkg;

    localparam int DATA_W = 24;
    localparam int REG_W  = 4;
    localparam int NREGS  = 16;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BRANCH = 4'hD;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              is_load;
        logic              we;
    } id_ex_t;

    // All-zero bundle doubles as the bubble because OP_NOP encodes as zero.
    localparam id_ex_t BUBBLE = id_ex_t'('0);

    function automatic logic writes_reg(input logic [3:0] op);
        return !(op == OP_STORE || op == OP_BRANCH || op == OP_NOP);
    endfunction

endpackage

// File: rtl/register_file.sv
// Register file with two read ports and one write port; R0 is hard-wired to zero.
// Reads see the value the register will hold after this cycle's write (bypass).
module register_file
    import cpu_pkg::*;
#(
    parameter int DW    = 24,
    parameter int NR    = 16,
    parameter int RW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] rs1_addr_i,
    input  logic [RW-1:0] rs2_addr_i,
    output logic [DW-1:0] rs1_data_o,
    output logic [DW-1:0] rs2_data_o,
    input  logic          we_i,
    input  logic [RW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i
);

    logic [DW-1:0] regs_q [NR];
    logic [DW-1:0] regs_d [NR];

    always_comb begin
        regs_d = regs_q;
        if (we_i && wr_addr_i != '0) begin
            regs_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reading the next-state array gives same-cycle writeback forwarding for free.
    always_comb begin
        rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_d[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_d[rs2_addr_i];
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, operand read, load-use hazard detection and
// the registered ID/EX bundle, with flush and stall both inserting bubbles.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              wb_we_i,
    input  logic [REG_W-1:0]  wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [3:0]        opcode_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc_o,
    output logic              is_load_o,
    output logic              we_o
);

    id_ex_t             bundle_q;
    id_ex_t             bundle_d;
    logic [3:0]         opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;

    assign opcode = instr_i[23:20];
    assign rd     = instr_i[19:16];
    assign rs1    = instr_i[15:12];
    assign rs2    = instr_i[11:8];
    assign imm    = {{(DATA_W-12){instr_i[11]}}, instr_i[11:0]};

    register_file #(
        .DW (DATA_W),
        .NR (NREGS),
        .RW (REG_W)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .we_i       (wb_we_i),
        .wr_addr_i  (wb_rd_i),
        .wr_data_i  (wb_data_i)
    );

    // The bubble that follows a stall clears is_load, so a stall lasts one cycle.
    assign stall_o = bundle_q.valid && bundle_q.is_load && (bundle_q.rd != '0) &&
                     ((bundle_q.rd == rs1) || (bundle_q.rd == rs2));

    always_comb begin
        bundle_d = BUBBLE;
        if (!(flush_i || stall_o)) begin
            bundle_d.valid    = 1'b1;
            bundle_d.opcode   = opcode;
            bundle_d.rd       = rd;
            bundle_d.rs1_data = rs1_data;
            bundle_d.rs2_data = rs2_data;
            bundle_d.imm      = imm;
            bundle_d.pc       = pc_i;
            bundle_d.is_load  = (opcode == OP_LOAD);
            bundle_d.we       = writes_reg(opcode);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bundle_q <= BUBBLE;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign valid_o    = bundle_q.valid;
    assign opcode_o   = bundle_q.opcode;
    assign rd_o       = bundle_q.rd;
    assign rs1_data_o = bundle_q.rs1_data;
    assign rs2_data_o = bundle_q.rs2_data;
    assign imm_o      = bundle_q.imm;
    assign pc_o       = bundle_q.pc;
    assign is_load_o  = bundle_q.is_load;
    assign we_o       = bundle_q.we;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model of the decode stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] instr_i;
    logic [23:0] pc_i;
    logic        flush_i;
    logic        wb_we_i;
    logic [3:0]  wb_rd_i;
    logic [23:0] wb_data_i;
    logic        stall_o;
    logic        valid_o;
    logic [3:0]  opcode_o;
    logic [3:0]  rd_o;
    logic [23:0] rs1_data_o;
    logic [23:0] rs2_data_o;
    logic [23:0] imm_o;
    logic [23:0] pc_o;
    logic        is_load_o;
    logic        we_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .wb_we_i    (wb_we_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .stall_o    (stall_o),
        .valid_o    (valid_o),
        .opcode_o   (opcode_o),
        .rd_o       (rd_o),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .imm_o      (imm_o),
        .pc_o       (pc_o),
        .is_load_o  (is_load_o),
        .we_o       (we_o)
    );

    wire [106:0] dut_vec = {valid_o, opcode_o, rd_o, rs1_data_o, rs2_data_o,
                            imm_o, pc_o, is_load_o, we_o};

    // Reference model: architectural registers and the expected decoded instruction.
    logic [23:0] mregs [16];
    logic        e_valid;
    logic [3:0]  e_opcode;
    logic [3:0]  e_rd;
    logic [23:0] e_rs1d;
    logic [23:0] e_rs2d;
    logic [23:0] e_imm;
    logic [23:0] e_pc;
    logic        e_is_load;
    logic        e_we;

    function automatic logic [106:0] exp_vec();
        return {e_valid, e_opcode, e_rd, e_rs1d, e_rs2d, e_imm, e_pc, e_is_load, e_we};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 24'h0;
        e_valid = 0; e_opcode = 0; e_rd = 0; e_rs1d = 0; e_rs2d = 0;
        e_imm = 0; e_pc = 0; e_is_load = 0; e_we = 0;
    endfunction

    function automatic logic model_stall();
        logic [3:0] s1;
        logic [3:0] s2;
        s1 = instr_i[15:12];
        s2 = instr_i[11:8];
        return e_valid && e_is_load && (e_rd != 0) && (e_rd == s1 || e_rd == s2);
    endfunction

    // Operands see the register value as it stands after this cycle's writeback.
    function automatic void model_edge();
        logic st;
        logic [3:0] op;
        logic [3:0] s1;
        logic [3:0] s2;
        st = model_stall();
        if (wb_we_i && wb_rd_i != 0) mregs[wb_rd_i] = wb_data_i;
        if (flush_i || st) begin
            e_valid = 0; e_opcode = 0; e_rd = 0; e_rs1d = 0; e_rs2d = 0;
            e_imm = 0; e_pc = 0; e_is_load = 0; e_we = 0;
        end else begin
            op = instr_i[23:20];
            s1 = instr_i[15:12];
            s2 = instr_i[11:8];
            e_valid   = 1;
            e_opcode  = op;
            e_rd      = instr_i[19:16];
            e_rs1d    = (s1 == 0) ? 24'h0 : mregs[s1];
            e_rs2d    = (s2 == 0) ? 24'h0 : mregs[s2];
            e_imm     = 24'(signed'(instr_i[11:0]));
            e_pc      = pc_i;
            e_is_load = (op == 4'h8);
            e_we      = !(op == 4'h9 || op == 4'hD || op == 4'h0);
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [23:0] instr, input logic [23:0] pc, input logic flush,
                         input logic we, input logic [3:0] rd, input logic [23:0] data);
        instr_i   = instr;
        pc_i      = pc;
        flush_i   = flush;
        wb_we_i   = we;
        wb_rd_i   = rd;
        wb_data_i = data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(24'h000000, 24'h0, 1'b0, 1'b0, 4'h0, 24'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 107'h0) $display("[TB] FAIL reset_outputs: got %h expected 0", dut_vec);
        else passes++;
        checks++;
        if (stall_o !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall_o);
        else passes++;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        drive(24'h020011, 24'h000000, 1'b0, 1'b0, 4'h0, 24'h0);
        tick();
        checks++;
        if ({valid_o, opcode_o, rd_o, imm_o} !== {1'b1, 4'h0, 4'h2, 24'h000011})
            $display("[TB] FAIL first_decode: got v=%b op=%h rd=%h imm=%h expected v=1 op=0 rd=2 imm=000011",
                     valid_o, opcode_o, rd_o, imm_o);
        else passes++;
        checks++;
        if (we_o !== 1'b0) $display("[TB] FAIL nop_we: got %b expected 0", we_o);
        else passes++;
    endtask

    task automatic test_bypass();
        drive(24'h153000, 24'h000004, 1'b0, 1'b1, 4'h3, 24'h00ABCD);
        tick();
        checks++;
        if (rs1_data_o !== 24'h00ABCD) $display("[TB] FAIL bypass_rs1: got %h expected 00abcd", rs1_data_o);
        else passes++;
        drive(24'h163000, 24'h000008, 1'b0, 1'b0, 4'h0, 24'h0);
        tick();
        checks++;
        if (rs1_data_o !== 24'h00ABCD) $display("[TB] FAIL stored_r3: got %h expected 00abcd", rs1_data_o);
        else passes++;
    endtask

    task automatic test_load_use();
        drive(24'h841000, 24'h00000C, 1'b0, 1'b0, 4'h0, 24'h0);
        tick();
        checks++;
        if ({valid_o, is_load_o, rd_o} !== {1'b1, 1'b1, 4'h4})
            $display("[TB] FAIL load_decode: got v=%b ld=%b rd=%h expected v=1 ld=1 rd=4", valid_o, is_load_o, rd_o);
        else passes++;
        drive(24'h150400, 24'h000010, 1'b0, 1'b0, 4'h0, 24'h0);
        #1;
        checks++;
        if (stall_o !== 1'b1) $display("[TB] FAIL load_use_stall: got %b expected 1", stall_o);
        else passes++;
        tick();
        checks++;
        if ({valid_o, we_o, is_load_o, stall_o} !== 4'b0000)
            $display("[TB] FAIL stall_bubble: got v=%b we=%b ld=%b st=%b expected all 0",
                     valid_o, we_o, is_load_o, stall_o);
        else passes++;
        tick();
        checks++;
        if ({valid_o, opcode_o, rd_o, pc_o} !== {1'b1, 4'h1, 4'h5, 24'h000010})
            $display("[TB] FAIL after_stall: got v=%b op=%h rd=%h pc=%h expected v=1 op=1 rd=5 pc=000010",
                     valid_o, opcode_o, rd_o, pc_o);
        else passes++;
    endtask

    task automatic test_flush();
        drive(24'hC00031, 24'h000014, 1'b1, 1'b0, 4'h0, 24'h0);
        tick();
        checks++;
        if ({valid_o, we_o} !== 2'b00) $display("[TB] FAIL flush_bubble: got v=%b we=%b expected 0 0", valid_o, we_o);
        else passes++;
        drive(24'h841000, 24'h000018, 1'b0, 1'b0, 4'h0, 24'h0);
        tick();
        drive(24'h104000, 24'h00001C, 1'b1, 1'b0, 4'h0, 24'h0);
        #1;
        checks++;
        if (stall_o !== 1'b1) $display("[TB] FAIL flush_stall_pre: got %b expected 1", stall_o);
        else passes++;
        tick();
        checks++;
        if ({valid_o, stall_o} !== 2'b00) $display("[TB] FAIL flush_over_stall: got v=%b st=%b expected 0 0", valid_o, stall_o);
        else passes++;
        flush_i = 1'b0;
    endtask

    task automatic test_r0_imm();
        drive(24'h120800, 24'h000020, 1'b0, 1'b1, 4'h0, 24'hFFFFFF);
        tick();
        checks++;
        if (rs1_data_o !== 24'h0) $display("[TB] FAIL r0_read: got %h expected 000000", rs1_data_o);
        else passes++;
        checks++;
        if (imm_o !== 24'hFFF800) $display("[TB] FAIL imm_sign: got %h expected fff800", imm_o);
        else passes++;
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: op = 4'h8;
                1: op = 4'h9;
                default: op = 4'($urandom_range(0, 15));
            endcase
            drive({op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 8'($urandom)},
                  24'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 7)), 24'($urandom));
            #1;
            checks++;
            if (stall_o !== model_stall()) $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", n, stall_o, model_stall());
            else passes++;
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("[TB] FAIL rand_bundle[%0d]: got %h expected %h", n, dut_vec, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        drive(24'h250000, 24'h000ABC, 1'b0, 1'b1, 4'h5, 24'h123456);
        tick();
        checks++;
        if (valid_o !== 1'b1) $display("[TB] FAIL pre_reset_valid: got %b expected 1", valid_o);
        else passes++;
        drive(24'h845000, 24'h000AC0, 1'b0, 1'b0, 4'h0, 24'h0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 107'h0) $display("[TB] FAIL async_reset_outputs: got %h expected 0", dut_vec);
        else passes++;
        checks++;
        if (stall_o !== 1'b0) $display("[TB] FAIL async_reset_stall: got %b expected 0", stall_o);
        else passes++;
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        drive(24'h155000, 24'h000AC4, 1'b0, 1'b0, 4'h0, 24'h0);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) $display("[TB] FAIL post_reset_regs: got %h expected %h", dut_vec, exp_vec());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_load_use();
        test_flush();
        test_r0_imm();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
